// File: rtl/systolic_tile_scheduler.sv
// Tile-level sequencer for the systolic array: walks output tiles m-outer/n-inner with K-steps innermost.
// Optional perf counters (stall / calc cycle counts) are built when SCHED_PERF_CNT_EN is defined.
module systolic_tile_scheduler #(
    parameter int M_TILES     = 2,
    parameter int N_TILES     = 2,
    parameter int K_STEPS     = 4,
    parameter int SLICE_BEATS = 256,
    parameter int ADDR_W      = 24,
    parameter int A_BASE      = 0,
    parameter int B_BASE      = 4096
) (
    input  logic              s_clk,
    input  logic              s_rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              a_req_valid,
    input  logic              a_req_ready,
    output logic [ADDR_W-1:0] a_req_addr,
    output logic              b_req_valid,
    input  logic              b_req_ready,
    output logic [ADDR_W-1:0] b_req_addr,
    input  logic              a_slice_done,
    input  logic              b_slice_done,
    output logic              sa_calc_start,
    input  logic              sa_calc_done,
    output logic              sa_drain_start,
    input  logic              sa_drain_done,
    output logic [7:0]        tile_m,
    output logic [7:0]        tile_n,
    output logic [7:0]        tile_k
`ifdef SCHED_PERF_CNT_EN
    ,
    output logic [31:0]       perf_stall_cycles,
    output logic [31:0]       perf_calc_cycles
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_LOAD, S_CALC, S_WAIT_CALC, S_DRAIN, S_WAIT_DRAIN, S_FIN
    } state_t;

    localparam logic [7:0] M_LAST = 8'(M_TILES - 1);
    localparam logic [7:0] N_LAST = 8'(N_TILES - 1);
    localparam logic [7:0] K_LAST = 8'(K_STEPS - 1);

    // Wide intermediate so the product never wraps before the final truncation to ADDR_W.
    function automatic logic [ADDR_W-1:0] slice_addr(input logic [63:0] base,
                                                      input logic [7:0] idx,
                                                      input logic [7:0] k);
        logic [63:0] full;
        full = base + (64'(idx) * 64'(K_STEPS) + 64'(k)) * 64'(SLICE_BEATS);
        return full[ADDR_W-1:0];
    endfunction

    state_t            state_q, state_d;
    logic [7:0]        m_q, m_d, n_q, n_d, k_q, k_d;
    logic              a_vld_q, a_vld_d, b_vld_q, b_vld_d;
    logic [ADDR_W-1:0] a_addr_q, a_addr_d, b_addr_q, b_addr_d;
    logic              a_got_q, a_got_d, b_got_q, b_got_d;
    logic              a_hs, b_hs, issue_go;

    assign a_hs = a_vld_q & a_req_ready;
    assign b_hs = b_vld_q & b_req_ready;

    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        n_d      = n_q;
        k_d      = k_q;
        a_vld_d  = a_vld_q;
        b_vld_d  = b_vld_q;
        a_addr_d = a_addr_q;
        b_addr_d = b_addr_q;
        a_got_d  = a_got_q;
        b_got_d  = b_got_q;
        issue_go = 1'b0;

        if (state_q == S_ISSUE || state_q == S_WAIT_LOAD) begin
            if (a_slice_done) a_got_d = 1'b1;
            if (b_slice_done) b_got_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    m_d      = '0;
                    n_d      = '0;
                    k_d      = '0;
                    issue_go = 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (a_hs) a_vld_d = 1'b0;
                if (b_hs) b_vld_d = 1'b0;
                if ((!a_vld_q || a_hs) && (!b_vld_q || b_hs)) state_d = S_WAIT_LOAD;
            end
            S_WAIT_LOAD: begin
                if (a_got_q && b_got_q) begin
                    a_got_d = 1'b0;
                    b_got_d = 1'b0;
                    state_d = S_CALC;
                end
            end
            S_CALC: state_d = S_WAIT_CALC;
            S_WAIT_CALC: begin
                if (sa_calc_done) begin
                    if (k_q == K_LAST) begin
                        state_d = S_DRAIN;
                    end else begin
                        k_d      = k_q + 8'd1;
                        issue_go = 1'b1;
                        state_d  = S_ISSUE;
                    end
                end
            end
            S_DRAIN: state_d = S_WAIT_DRAIN;
            S_WAIT_DRAIN: begin
                if (sa_drain_done) begin
                    k_d = '0;
                    if (n_q == N_LAST) begin
                        n_d = '0;
                        // Indices wrap back to zero once the last tile has drained.
                        if (m_q == M_LAST) begin
                            m_d     = '0;
                            state_d = S_FIN;
                        end else begin
                            m_d      = m_q + 8'd1;
                            issue_go = 1'b1;
                            state_d  = S_ISSUE;
                        end
                    end else begin
                        n_d      = n_q + 8'd1;
                        issue_go = 1'b1;
                        state_d  = S_ISSUE;
                    end
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (issue_go) begin
            a_vld_d  = 1'b1;
            b_vld_d  = 1'b1;
            a_addr_d = slice_addr(64'(A_BASE), m_d, k_d);
            b_addr_d = slice_addr(64'(B_BASE), n_d, k_d);
        end
    end

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            state_q  <= S_IDLE;
            m_q      <= '0;
            n_q      <= '0;
            k_q      <= '0;
            a_vld_q  <= 1'b0;
            b_vld_q  <= 1'b0;
            a_addr_q <= '0;
            b_addr_q <= '0;
            a_got_q  <= 1'b0;
            b_got_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            m_q      <= m_d;
            n_q      <= n_d;
            k_q      <= k_d;
            a_vld_q  <= a_vld_d;
            b_vld_q  <= b_vld_d;
            a_addr_q <= a_addr_d;
            b_addr_q <= b_addr_d;
            a_got_q  <= a_got_d;
            b_got_q  <= b_got_d;
        end
    end

    assign busy           = (state_q != S_IDLE) && (state_q != S_FIN);
    assign done           = (state_q == S_FIN);
    assign sa_calc_start  = (state_q == S_CALC);
    assign sa_drain_start = (state_q == S_DRAIN);
    assign a_req_valid    = a_vld_q;
    assign b_req_valid    = b_vld_q;
    assign a_req_addr     = a_addr_q;
    assign b_req_addr     = b_addr_q;
    assign tile_m         = m_q;
    assign tile_n         = n_q;
    assign tile_k         = k_q;

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] stall_q, stall_d, calc_q, calc_d;

    always_comb begin
        stall_d = stall_q;
        calc_d  = calc_q;
        if (state_q == S_IDLE && start) begin
            stall_d = '0;
            calc_d  = '0;
        end else begin
            if ((state_q == S_ISSUE || state_q == S_WAIT_LOAD) && stall_q != 32'hFFFF_FFFF)
                stall_d = stall_q + 32'd1;
            if ((state_q == S_CALC || state_q == S_WAIT_CALC) && calc_q != 32'hFFFF_FFFF)
                calc_d = calc_q + 32'd1;
        end
    end

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            stall_q <= '0;
            calc_q  <= '0;
        end else begin
            stall_q <= stall_d;
            calc_q  <= calc_d;
        end
    end

    assign perf_stall_cycles = stall_q;
    assign perf_calc_cycles  = calc_q;
`endif

endmodule

// File: tb/tb_systolic_tile_scheduler.sv
// Self-checking bench: negedge responder/monitor with randomizable latencies, checked against a
// tile-order request list built from the address formula.
module tb_systolic_tile_scheduler;
    localparam int M  = 2;
    localparam int N  = 2;
    localparam int K  = 4;
    localparam int SB = 256;
    localparam int AW = 24;
    localparam int AB = 0;
    localparam int BB = 4096;

    logic          s_clk = 1'b0;
    logic          s_rst, start, busy, done;
    logic          a_req_valid, a_req_ready, b_req_valid, b_req_ready;
    logic [AW-1:0] a_req_addr, b_req_addr;
    logic          a_slice_done, b_slice_done;
    logic          sa_calc_start, sa_calc_done, sa_drain_start, sa_drain_done;
    logic [7:0]    tile_m, tile_n, tile_k;
`ifdef SCHED_PERF_CNT_EN
    logic [31:0]   perf_stall_cycles, perf_calc_cycles;
`endif

    systolic_tile_scheduler #(
        .M_TILES(M), .N_TILES(N), .K_STEPS(K), .SLICE_BEATS(SB),
        .ADDR_W(AW), .A_BASE(AB), .B_BASE(BB)
    ) dut (
        .s_clk(s_clk), .s_rst(s_rst), .start(start), .busy(busy), .done(done),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_addr(a_req_addr),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_addr(b_req_addr),
        .a_slice_done(a_slice_done), .b_slice_done(b_slice_done),
        .sa_calc_start(sa_calc_start), .sa_calc_done(sa_calc_done),
        .sa_drain_start(sa_drain_start), .sa_drain_done(sa_drain_done),
        .tile_m(tile_m), .tile_n(tile_n), .tile_k(tile_k)
`ifdef SCHED_PERF_CNT_EN
        , .perf_stall_cycles(perf_stall_cycles), .perf_calc_cycles(perf_calc_cycles)
`endif
    );

    always #5 s_clk = ~s_clk;

    typedef struct { int m; int n; int k; longint a; longint b; } req_t;
    req_t exp_q[$];

    int tests = 0;
    int errs  = 0;

    // Responder knobs; with rand_en the value is the upper bound of a random draw.
    int a_hold = 0, b_hold = 0, a_sdly = 3, b_sdly = 3, c_dly = 3, d_dly = 3;
    bit rand_en = 0, stray_en = 0;

    int     cyc = 0, calc_cnt = 0, drain_cnt = 0, done_cnt = 0, last_dn = 0;
    bit     hit_102 = 0;
    longint b_n1k2 = -1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int pick(input int mx, input int mn);
        return rand_en ? int'($urandom_range(mx, mn)) : mx;
    endfunction

    task automatic build_exp();
        exp_q.delete();
        for (int m = 0; m < M; m++)
            for (int n = 0; n < N; n++)
                for (int k = 0; k < K; k++)
                    exp_q.push_back('{m, n, k,
                                      (longint'(AB) + longint'((m * K + k) * SB)) % (64'd1 << AW),
                                      (longint'(BB) + longint'((n * K + k) * SB)) % (64'd1 << AW)});
    endtask

    // Responder + monitor: everything sampled and driven on the falling edge.
    initial begin : responder
        int a_len, b_len, a_hcur, b_hcur, a_tmr, b_tmr, c_tmr, d_tmr;
        bit a_prev, b_prev, a_dn, b_dn;
        logic [AW-1:0] a_addr_prev, b_addr_prev;
        req_t e;
        a_req_ready = 0; b_req_ready = 0; a_slice_done = 0; b_slice_done = 0;
        sa_calc_done = 0; sa_drain_done = 0;
        a_len = 0; b_len = 0; a_hcur = 0; b_hcur = 0;
        a_tmr = -1; b_tmr = -1; c_tmr = -1; d_tmr = -1;
        a_prev = 0; b_prev = 0; a_dn = 0; b_dn = 0;
        a_addr_prev = '0; b_addr_prev = '0;
        forever begin
            @(negedge s_clk);
            cyc++;
            if (s_rst) begin
                a_req_ready = 0; b_req_ready = 0; a_slice_done = 0; b_slice_done = 0;
                sa_calc_done = 0; sa_drain_done = 0;
                a_tmr = -1; b_tmr = -1; c_tmr = -1; d_tmr = -1;
                a_prev = 0; b_prev = 0; a_dn = 0; b_dn = 0;
                continue;
            end

            sa_calc_done = 0;
            if (c_tmr > 0) begin
                c_tmr--;
                if (c_tmr == 0) begin sa_calc_done = 1; c_tmr = -1; end
            end
            sa_drain_done = 0;
            if (d_tmr > 0) begin
                d_tmr--;
                if (d_tmr == 0) begin sa_drain_done = 1; d_tmr = -1; end
            end

            if (a_req_valid && !a_prev) begin
                chk("b_valid_with_a", b_req_valid, 1);
                chk("req_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("a_req_addr", a_req_addr, e.a);
                    chk("b_req_addr", b_req_addr, e.b);
                    chk("tile_m", tile_m, e.m);
                    chk("tile_n", tile_n, e.n);
                    chk("tile_k", tile_k, e.k);
                    if (e.m == 0 && e.n == 1 && e.k == 2) b_n1k2 = longint'(b_req_addr);
                end
                a_len = 0; a_hcur = pick(a_hold, 0);
            end
            if (b_req_valid && !b_prev) begin
                b_len = 0; b_hcur = pick(b_hold, 0);
            end
            if (a_req_valid) begin
                if (a_prev) chk("a_addr_stable", a_req_addr, a_addr_prev);
                a_len++;
            end else if (a_prev) chk("a_valid_len", a_len, a_hcur + 1);
            if (b_req_valid) begin
                if (b_prev) chk("b_addr_stable", b_req_addr, b_addr_prev);
                b_len++;
            end else if (b_prev) chk("b_valid_len", b_len, b_hcur + 1);
            a_prev = a_req_valid; a_addr_prev = a_req_addr;
            b_prev = b_req_valid; b_addr_prev = b_req_addr;

            if (sa_calc_start) begin
                chk("calc_after_slices", a_dn && b_dn, 1);
                chk("calc_latency", cyc - last_dn, 2);
                a_dn = 0; b_dn = 0;
                calc_cnt++;
                c_tmr = pick(c_dly, 1);
                if (tile_m == 1 && tile_n == 0 && tile_k == 2) hit_102 = 1;
            end
            if (sa_drain_start) begin
                drain_cnt++;
                chk("calc_per_drain", calc_cnt, drain_cnt * K);
                d_tmr = pick(d_dly, 1);
            end
            if (done) begin
                done_cnt++;
                chk("busy_low_at_done", busy, 0);
                chk("all_reqs_issued", exp_q.size(), 0);
            end

            a_req_ready = a_req_valid && (a_len > a_hcur);
            b_req_ready = b_req_valid && (b_len > b_hcur);
            if (a_req_ready) a_tmr = pick(a_sdly, 0);
            if (b_req_ready) b_tmr = pick(b_sdly, 0);
            a_slice_done = 0;
            b_slice_done = 0;
            if (a_tmr >= 0) begin
                if (a_tmr == 0) begin a_slice_done = 1; a_dn = 1; last_dn = cyc; end
                a_tmr--;
            end
            if (b_tmr >= 0) begin
                if (b_tmr == 0) begin b_slice_done = 1; b_dn = 1; last_dn = cyc; end
                b_tmr--;
            end

            if (stray_en) begin
                if (a_req_valid && b_req_valid) begin sa_calc_done = 1; sa_drain_done = 1; end
                if (sa_calc_start) begin a_slice_done = 1; b_slice_done = 1; end
            end
        end
    end

    task automatic chk_idle(input string pfx);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_done"}, done, 0);
        chk({pfx, "_a_valid"}, a_req_valid, 0);
        chk({pfx, "_b_valid"}, b_req_valid, 0);
        chk({pfx, "_a_addr"}, a_req_addr, 0);
        chk({pfx, "_b_addr"}, b_req_addr, 0);
        chk({pfx, "_calc_start"}, sa_calc_start, 0);
        chk({pfx, "_drain_start"}, sa_drain_start, 0);
        chk({pfx, "_tile_m"}, tile_m, 0);
        chk({pfx, "_tile_n"}, tile_n, 0);
        chk({pfx, "_tile_k"}, tile_k, 0);
    endtask

    task automatic run_job(input int stray_at);
        build_exp();
        calc_cnt = 0; drain_cnt = 0; done_cnt = 0;
        chk("idle_before_start", busy, 0);
        start = 1;
        @(negedge s_clk);
        start = 0;
        chk("busy_after_start", busy, 1);
        for (int i = 0; i < 20000 && done_cnt == 0; i++) begin
            @(negedge s_clk);
            if (i == stray_at) begin
                chk("busy_at_stray_start", busy, 1);
                start = 1;
                @(negedge s_clk);
                start = 0;
            end
        end
        chk("job_done_seen", done_cnt, 1);
        repeat (4) @(negedge s_clk);
        chk("calc_count", calc_cnt, M * N * K);
        chk("drain_count", drain_cnt, M * N);
        chk("done_count", done_cnt, 1);
        chk("busy_after_done", busy, 0);
    endtask

    initial begin : main
        s_rst = 1;
        start = 0;
        repeat (3) @(negedge s_clk);
        chk_idle("rst");
        s_rst = 0;
        @(negedge s_clk);

        // Fixed 3-cycle responders.
        run_job(-1);
        chk("b_addr_n1_k2", b_n1k2, 5632);

        // A held off 10 cycles, B accepted immediately.
        a_hold = 10; b_hold = 0; a_sdly = 1; b_sdly = 1;
        run_job(-1);

        // B slice done with its handshake, A slice done 5 cycles later.
        a_hold = 0; a_sdly = 5; b_sdly = 0;
        run_job(-1);

        // Stray calc/drain/slice pulses and a start while busy.
        a_sdly = 2; b_sdly = 2; stray_en = 1;
        run_job(40);
        stray_en = 0;

        // Randomized latencies.
        rand_en = 1; a_hold = 4; b_hold = 4; a_sdly = 6; b_sdly = 6; c_dly = 4; d_dly = 4;
        for (int r = 0; r < 3; r++) run_job(-1);
        rand_en = 0; a_hold = 0; b_hold = 0; a_sdly = 1; b_sdly = 1; c_dly = 6; d_dly = 2;

        // Reset while waiting on a compute step at tile (1,0,2).
        build_exp();
        hit_102 = 0;
        start = 1;
        @(negedge s_clk);
        start = 0;
        for (int i = 0; i < 5000 && !hit_102; i++) @(negedge s_clk);
        chk("reached_1_0_2", hit_102, 1);
        @(negedge s_clk);
        chk("busy_before_rst", busy, 1);
        s_rst = 1;
        #1;
        chk_idle("midrst");
        repeat (2) @(negedge s_clk);
        s_rst = 0;
        @(negedge s_clk);
        c_dly = 3;
        run_job(-1);

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end
endmodule

// File: doc/systolic_tile_scheduler.md
Name: systolic_tile_scheduler

Overview:
- Sequences the systolic array over a tiled matrix product C = A x B.
- Output tiles are ordered m-outer, n-inner; K-steps are innermost.
- For each step the block issues A-slice and B-slice fetch requests to the slice generators and waits for both slice-done pulses.
- It then triggers one array compute step, and after the last K-step triggers result drain before moving to the next tile.

Parameters:
- M_TILES, 2, number of A row tiles (1..255)
- N_TILES, 2, number of B column tiles (1..255)
- K_STEPS, 4, slices accumulated per output tile (1..255)
- SLICE_BEATS, 256, data beats per slice; sets address stride
- ADDR_W, 24, request address width (beat units)
- A_BASE, 0, A region base address (beats)
- B_BASE, 4096, B region base address (beats)

Ports:
- s_clk  in  1  clock
- s_rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle start pulse; ignored unless IDLE
- busy  out  1  high from the cycle after start accept until done
- done  out  1  one-cycle pulse after the final drain completes
- a_req_valid  out  1  A fetch request valid
- a_req_ready  in  1  A fetch request accept
- a_req_addr  out  ADDR_W  A slice start address
- b_req_valid  out  1  B fetch request valid
- b_req_ready  in  1  B fetch request accept
- b_req_addr  out  ADDR_W  B slice start address
- a_slice_done  in  1  pulse: A slice fully delivered to array
- b_slice_done  in  1  pulse: B slice fully delivered to array
- sa_calc_start  out  1  one-cycle pulse: run one compute step
- sa_calc_done  in  1  pulse: compute step finished
- sa_drain_start  out  1  one-cycle pulse: drain accumulated tile
- sa_drain_done  in  1  pulse: drain finished
- tile_m  out  8  current m index
- tile_n  out  8  current n index
- tile_k  out  8  current k index

Behaviour:
- Reset: s_rst is asynchronous, active-high; clock is s_clk. On reset the FSM goes to IDLE and all outputs are 0, including the indices, addresses and sticky flags. Reset mid-operation abandons the current step; no pulse is emitted.
- FSM states: IDLE, ISSUE, WAIT_LOAD, CALC, WAIT_CALC, DRAIN, WAIT_DRAIN, FIN.
- IDLE:
  - start=1 -> ISSUE; indices cleared to 0; busy=1 from the next cycle.
- ISSUE:
  - a_req_valid and b_req_valid are registered and asserted together on ISSUE entry.
  - Each drops on its own handshake (valid & ready); addr is held stable while valid.
  - a_req_addr = A_BASE + (tile_m*K_STEPS + tile_k)*SLICE_BEATS; b_req_addr = B_BASE + (tile_n*K_STEPS + tile_k)*SLICE_BEATS. Both are truncated to ADDR_W.
  - When both requests have been accepted (can be the same cycle) -> WAIT_LOAD.
- Slice-done flags:
  - Sticky a_got/b_got are set by a_slice_done/b_slice_done in ISSUE or WAIT_LOAD, including a done in the same cycle as its handshake.
  - The flags are cleared on CALC entry.
- WAIT_LOAD: a_got & b_got -> CALC.
- CALC: sa_calc_start=1 for exactly one cycle -> WAIT_CALC.
- WAIT_CALC:
  - sa_calc_done -> if tile_k==K_STEPS-1, go to DRAIN; else tile_k+1 and go to ISSUE.
  - sa_calc_done is sampled only in WAIT_CALC.
- DRAIN: sa_drain_start=1 for one cycle -> WAIT_DRAIN.
- WAIT_DRAIN: sa_drain_done advances the tile:
  - tile_k=0, tile_n+1; on n wrap, tile_n=0 and tile_m+1.
  - If m and n were both last -> FIN; else -> ISSUE.
- FIN: done=1 for one cycle, busy=0 in the same cycle -> IDLE.
- Minimum latency per K-step is ISSUE(1) + WAIT_LOAD(1) + CALC(1) + WAIT_CALC(1) cycles with zero-wait responders.
- Stray pulses are ignored:
  - slice-done, calc_done or drain_done arriving in any other state has no effect.
  - start while busy has no effect.
- Degenerate case: M_TILES=N_TILES=K_STEPS=1 gives exactly one calc, one drain, one done.

Optional Feature:
- SCHED_PERF_CNT_EN defined:
  - Adds outputs perf_stall_cycles[31:0] and perf_calc_cycles[31:0].
  - stall counts cycles spent in ISSUE or WAIT_LOAD; calc counts cycles in CALC or WAIT_CALC.
  - Both clear on start accept and saturate at 0xFFFFFFFF; values hold after done.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Defaults, always-ready responders with done pulses 3 cycles after request -> 16 sa_calc_start, 4 sa_drain_start, 1 done; A addrs sequence 0,256,512,768 repeated per n; B addr for n=1,k=2 = 4096+1536=5632.
- a_req_ready held low 10 cycles while b accepts immediately -> b_req_valid drops after 1 cycle, a_req_valid held with stable addr, no CALC before both handshakes and both slice_done.
- b_slice_done in same cycle as b handshake, a_slice_done 5 cycles later -> exactly one sa_calc_start, 1 cycle after WAIT_LOAD sees both flags.
- Stray sa_calc_done/sa_drain_done pulses in ISSUE, plus start pulse while busy -> no state change, counts unchanged.
- Assert s_rst during WAIT_CALC at tile (1,0,2) -> all outputs 0 immediately; a new start restarts at (0,0,0) with a_req_addr=0.
- With SCHED_PERF_CNT_EN, M=N=K=1 and each slice done 4 cycles after handshake -> perf_stall_cycles=6, perf_calc_cycles equal to cycles from CALC to calc_done inclusive.
